// File: rtl/vec_addsub_pkg.sv
// vec_addsub_pkg: shared mode codes, security-level codes and controller
// states for the streaming modular adder/subtractor.
package vec_addsub_pkg;

    localparam logic [1:0] MODE_ADD    = 2'b00;
    localparam logic [1:0] MODE_SUB_AB = 2'b01;
    localparam logic [1:0] MODE_SUB_BA = 2'b10;
    localparam logic [1:0] MODE_ACC    = 2'b11;

    localparam logic [2:0] SEC_L1 = 3'b001;
    localparam logic [2:0] SEC_L3 = 3'b010;
    localparam logic [2:0] SEC_L5 = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vec_addsub_if.sv
// vec_addsub_if: job control plus input/output stream handshakes of vec_addsub.
// slave = the adder side, master = the producer/consumer side.
interface vec_addsub_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned LEN_W = 16
) ();
    logic [2:0]             i_sec_lev;
    logic                   i_start;
    logic [1:0]             i_mode;
    logic [LEN_W-1:0]       i_len;
    logic                   o_busy;
    logic                   o_done;
    logic                   i_valid;
    logic                   o_ready;
    logic [LANES*WIDTH-1:0] i_a;
    logic [LANES*WIDTH-1:0] i_b;
    logic                   o_valid;
    logic                   i_ready;
    logic [LANES*WIDTH-1:0] o_c;
    logic                   o_last;

    modport slave (
        input  i_sec_lev, i_start, i_mode, i_len, i_valid, i_a, i_b, i_ready,
        output o_busy, o_done, o_ready, o_valid, o_c, o_last
    );

    modport master (
        output i_sec_lev, i_start, i_mode, i_len, i_valid, i_a, i_b, i_ready,
        input  o_busy, o_done, o_ready, o_valid, o_c, o_last
    );
endinterface

// File: rtl/vec_addsub_lane_addsub.sv
// lane_addsub: one combinational coefficient lane. Computes a+b, a-b or b-a
// with natural wrap mod 2^WIDTH; the L1 flag clears the top bit (q = 2^15).
module lane_addsub
    import vec_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             l1,
    output logic [WIDTH-1:0] r
);

    // Select the operation, then apply the L1 modulus mask.
    always_comb begin
        case (mode)
            MODE_SUB_AB: r = a - b;
            MODE_SUB_BA: r = b - a;
            default:     r = a + b;
        endcase
        if (l1) begin
            r[WIDTH-1] = 1'b0;
        end
    end

endmodule

// File: rtl/vec_addsub.sv
// vec_addsub: streaming multi-lane modular adder/subtractor with job control.
// Optional feature macro VEC_ADDSUB_ACC_EN enables accumulate mode (mode 11);
// without it mode 11 is a plain per-beat a+b.
module vec_addsub
    import vec_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned LEN_W = 16
) (
    input logic         i_clk,
    input logic         i_rst_n,
    vec_addsub_if.slave bus
);

    state_t                 state, state_nxt;
    logic [LEN_W-1:0]       len_q, cnt;
    logic [1:0]             mode_q;
    logic                   l1_q;
    logic                   out_valid, out_last, done;
    logic [LANES*WIDTH-1:0] out_c, lane_r, load_c;
    logic                   acc_mode, ready, accept, fire, last_beat, start_ok, load;

    assign start_ok  = (state == IDLE) && bus.i_start;
    assign fire      = out_valid && bus.i_ready;
    assign ready     = (state == RUN) && (acc_mode || !out_valid || bus.i_ready);
    assign accept    = bus.i_valid && ready;
    assign last_beat = (cnt == len_q - LEN_W'(1));
    // Accumulate jobs only load the output register on their final beat.
    assign load      = accept && (!acc_mode || last_beat);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_addsub #(.WIDTH(WIDTH)) u_lane (
            .a    (bus.i_a[k*WIDTH +: WIDTH]),
            .b    (bus.i_b[k*WIDTH +: WIDTH]),
            .mode (mode_q),
            .l1   (l1_q),
            .r    (lane_r[k*WIDTH +: WIDTH])
        );
    end

`ifdef VEC_ADDSUB_ACC_EN
    logic [LANES*WIDTH-1:0] acc, acc_nxt;

    assign acc_mode = (mode_q == MODE_ACC);
    assign load_c   = acc_mode ? acc_nxt : lane_r;

    // Mode 11 makes lane_r = mask(a+b); a second adder folds it into acc.
    for (genvar k = 0; k < LANES; k++) begin : g_acc
        lane_addsub #(.WIDTH(WIDTH)) u_acc (
            .a    (acc[k*WIDTH +: WIDTH]),
            .b    (lane_r[k*WIDTH +: WIDTH]),
            .mode (MODE_ADD),
            .l1   (l1_q),
            .r    (acc_nxt[k*WIDTH +: WIDTH])
        );
    end

    // Accumulator: cleared at job start, updated on every accepted beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc <= '0;
        end else if (start_ok) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_nxt;
        end
    end
`else
    assign acc_mode = 1'b0;
    assign load_c   = lane_r;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && (bus.i_len != '0)) state_nxt = RUN;
            RUN:     if (accept && last_beat)           state_nxt = DRAIN;
            DRAIN:   if (fire && out_last)              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job parameters, beat counter and the done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q  <= '0;
            mode_q <= MODE_ADD;
            l1_q   <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= (start_ok && (bus.i_len == '0)) || ((state == DRAIN) && fire && out_last);
            if (start_ok && (bus.i_len != '0)) begin
                len_q  <= bus.i_len;
                mode_q <= bus.i_mode;
                l1_q   <= (bus.i_sec_lev == SEC_L1);
                cnt    <= '0;
            end else if (accept) begin
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

    // Output register: loads on a producing beat, holds while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_c     <= load_c;
            out_last  <= last_beat;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.o_busy  = (state != IDLE);
    assign bus.o_done  = done;
    assign bus.o_ready = ready;
    assign bus.o_valid = out_valid;
    assign bus.o_c     = out_c;
    assign bus.o_last  = out_last;

endmodule
